// File: rtl/dmac_rd_arbiter_if.sv
// Requester-side and DMAC read-command signals of the read arbiter.
// Handshake: a requester holds req_valid with stable addr/size until its req_ready pulse.
`timescale 1ns/1ps
interface dmac_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*SIZE_WIDTH-1:0] req_size;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic                          Rd_go;
    logic [ADDR_WIDTH-1:0]         Rd_addr;
    logic [SIZE_WIDTH-1:0]         Rd_size;
    logic                          Rd_done;

    modport slave (
        input  req_valid, req_addr, req_size, Rd_done,
        output req_ready, req_done, req_err, grant_id, busy, Rd_go, Rd_addr, Rd_size
    );

    modport master (
        output req_valid, req_addr, req_size, Rd_done,
        input  req_ready, req_done, req_err, grant_id, busy, Rd_go, Rd_addr, Rd_size
    );
endinterface

// File: rtl/dmac_rd_arbiter.sv
// Round-robin owner of the DMAC read-command channel: one transfer at a time,
// each ending in a done or watchdog-error pulse to the granted requester.
`timescale 1ns/1ps
module dmac_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    dmac_rd_arbiter_if.slave   bus,
    output logic [1:0]         state_dbg
);
    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_LSB  = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [SIZE_WIDTH-1:0] rd_size_q, rd_size_d;
    logic                  rd_go_q, rd_go_d;
    logic                  busy_q, busy_d;
    logic                  zero_q, zero_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    req_done_q, req_done_d;
    logic [NUM_REQ-1:0]    req_err_q, req_err_d;

    logic                  win_found;
    logic [GW-1:0]         win_id;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [SIZE_WIDTH-1:0] win_size;
    logic [NUM_REQ-1:0]    gnt_oh;

    assign gnt_oh = ONE_LSB << grant_id_q;

    // Search from rr_ptr upward; the index is folded back below NUM_REQ so
    // non-power-of-two requester counts never select a missing slot.
    always_comb begin : arb
        logic [GW:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
            if (!win_found && bus.req_valid[idx[GW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == GW'(i)) begin
                win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_size = bus.req_size[i*SIZE_WIDTH +: SIZE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        rd_addr_d   = rd_addr_q;
        rd_size_d   = rd_size_q;
        busy_d      = busy_q;
        zero_d      = zero_q;
        wd_d        = wd_q;
        rd_go_d     = 1'b0;
        req_ready_d = '0;
        req_done_d  = '0;
        req_err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_id_d  = win_id;
                    rd_addr_d   = win_addr;
                    rd_size_d   = win_size;
                    req_ready_d = ONE_LSB << win_id;
                    if (win_size != '0) begin
                        state_d = S_ISSUE;
                        rd_go_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty transfer completes without touching the DMAC.
                        state_d = S_RESP;
                        zero_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (bus.Rd_done) begin
                    state_d    = S_RESP;
                    busy_d     = 1'b0;
                    req_done_d = gnt_oh;
                end else if (TIMEOUT != 0 && wd_q == WD_LIMIT) begin
                    state_d   = S_RESP;
                    busy_d    = 1'b0;
                    req_err_d = gnt_oh;
                end
            end
            S_RESP: begin
                if (zero_q) req_done_d = gnt_oh;
                zero_d   = 1'b0;
                rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            rd_addr_q   <= '0;
            rd_size_q   <= '0;
            rd_go_q     <= 1'b0;
            busy_q      <= 1'b0;
            zero_q      <= 1'b0;
            wd_q        <= '0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            rd_addr_q   <= rd_addr_d;
            rd_size_q   <= rd_size_d;
            rd_go_q     <= rd_go_d;
            busy_q      <= busy_d;
            zero_q      <= zero_d;
            wd_q        <= wd_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.req_done  = req_done_q;
    assign bus.req_err   = req_err_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
    assign bus.Rd_go     = rd_go_q;
    assign bus.Rd_addr   = rd_addr_q;
    assign bus.Rd_size   = rd_size_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_dmac_rd_arbiter.sv
// Directed bench for dmac_rd_arbiter: scripted stimulus pushes timestamped
// expected events; a monitor pops them as the DUT pulses its outputs.
`timescale 1ns/1ps
module tb_dmac_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int SW = 16;
    localparam int TO = 24;
    localparam int EW = 72;
    localparam logic [1:0] K_RDY = 2'd0, K_GO = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [EW-1:0] exp_q[$];

    dmac_rd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) bus();

    dmac_rd_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [3:0] pv,
                                         input logic [1:0] gid, input logic [31:0] a,
                                         input logic [15:0] s, input int c);
        return {k, pv, gid, a, s, 16'(c)};
    endfunction

    task automatic push(input logic [1:0] k, input int id, input logic [31:0] a,
                        input logic [15:0] s, input int c);
        logic [3:0] pv;
        pv = (k == K_GO) ? 4'b0000 : (4'b0001 << id);
        exp_q.push_back(mk(k, pv, 2'(id), a, s, c));
    endtask

    task automatic observe(input logic [EW-1:0] act);
        logic [EW-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got %h, expected none (queue empty) at cycle %0d", act, cyc);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL event: got %h, expected %h at cycle %0d", act, e, cyc);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: event kind, raw pulse vector, grant_id, Rd_addr, Rd_size, cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (|bus.req_ready)
                    observe(mk(K_RDY, bus.req_ready, bus.grant_id, bus.Rd_addr, bus.Rd_size, cyc));
                if (bus.Rd_go)
                    observe(mk(K_GO, 4'b0000, bus.grant_id, bus.Rd_addr, bus.Rd_size, cyc));
                if (|bus.req_done)
                    observe(mk(K_DONE, bus.req_done, bus.grant_id, bus.Rd_addr, bus.Rd_size, cyc));
                if (|bus.req_err)
                    observe(mk(K_ERR, bus.req_err, bus.grant_id, bus.Rd_addr, bus.Rd_size, cyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [15:0] s);
        bus.req_addr[id*AW +: AW] = a;
        bus.req_size[id*SW +: SW] = s;
        bus.req_valid[id]         = 1'b1;
    endtask

    // Raise one request while the DUT idles; returns the cycle of its ready pulse.
    task automatic issue(input int id, input logic [31:0] a, input logic [15:0] s, output int r);
        set_req(id, a, s);
        r = cyc + 1;
        push(K_RDY, id, a, s, r);
        if (s != 16'd0) push(K_GO, id, a, s, r);
        wait_cyc(r);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},    32'(state_dbg),     32'd0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id),  32'd0);
        chk({tag, "_rd_addr"},  bus.Rd_addr,        32'd0);
        chk({tag, "_rd_size"},  32'(bus.Rd_size),   32'd0);
        chk({tag, "_rd_go"},    32'(bus.Rd_go),     32'd0);
        chk({tag, "_busy"},     32'(bus.busy),      32'd0);
        chk({tag, "_ready"},    32'(bus.req_ready), 32'd0);
        chk({tag, "_done"},     32'(bus.req_done),  32'd0);
        chk({tag, "_err"},      32'(bus.req_err),   32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int d;
        int id;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.Rd_done   = 1'b0;
        #1;
        chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin: all four requesters valid, Rd_done returned 5 cycles after Rd_go.
        for (int i = 0; i < N; i++) set_req(i, 32'h2000 + 32'(i) * 32'h100, 16'(i + 1));
        r = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            id = k % N;
            push(K_RDY, id, 32'h2000 + 32'(id) * 32'h100, 16'(id + 1), r);
            push(K_GO,  id, 32'h2000 + 32'(id) * 32'h100, 16'(id + 1), r);
            wait_cyc(r + 5);
            chk("rr_busy", 32'(bus.busy), 32'd1);
            bus.Rd_done = 1'b1;
            push(K_DONE, id, 32'h2000 + 32'(id) * 32'h100, 16'(id + 1), r + 6);
            wait_cyc(r + 6);
            bus.Rd_done = 1'b0;
            if (k == 5) bus.req_valid = '0;
            d = r + 6;
            r = r + 8;
        end
        wait_cyc(d + 1);
        chk("rr_idle_busy", 32'(bus.busy), 32'd0);
        chk("rr_idle_state", 32'(state_dbg), 32'd0);

        // Single request from requester 2, Rd_done after 20 cycles.
        issue(2, 32'h1000, 16'd8, r);
        wait_cyc(r + 20);
        bus.Rd_done = 1'b1;
        push(K_DONE, 2, 32'h1000, 16'd8, r + 21);
        wait_cyc(r + 21);
        bus.Rd_done = 1'b0;
        d = r + 21;
        wait_cyc(d + 1);

        // Zero size: ready, then done one cycle later, no Rd_go.
        issue(1, 32'h3000, 16'd0, r);
        push(K_DONE, 1, 32'h3000, 16'd0, r + 1);
        d = r + 1;
        wait_cyc(d + 1);

        // Watchdog expiry, then a stray Rd_done while idle.
        issue(3, 32'h4000, 16'd4, r);
        push(K_ERR, 3, 32'h4000, 16'd4, r + 2 + TO);
        d = r + 2 + TO;
        wait_cyc(d + 1);
        bus.Rd_done = 1'b1;
        wait_cyc(d + 2);
        bus.Rd_done = 1'b0;
        chk("stray_idle_state", 32'(state_dbg), 32'd0);

        // Rd_done coinciding with the watchdog limit wins.
        issue(0, 32'h5000, 16'd2, r);
        wait_cyc(r + 1 + TO);
        bus.Rd_done = 1'b1;
        push(K_DONE, 0, 32'h5000, 16'd2, r + 2 + TO);
        wait_cyc(r + 2 + TO);
        bus.Rd_done = 1'b0;
        d = r + 2 + TO;
        wait_cyc(d + 1);

        // Rd_done during ISSUE is ignored.
        issue(1, 32'h6000, 16'd3, r);
        bus.Rd_done = 1'b1;
        wait_cyc(r + 1);
        bus.Rd_done = 1'b0;
        chk("issue_done_state", 32'(state_dbg), 32'd2);
        wait_cyc(r + 6);
        bus.Rd_done = 1'b1;
        push(K_DONE, 1, 32'h6000, 16'd3, r + 7);
        wait_cyc(r + 7);
        bus.Rd_done = 1'b0;
        d = r + 7;
        wait_cyc(d + 1);

        // Reset in WAIT, then lowest valid index wins after release.
        issue(2, 32'h7000, 16'd5, r);
        wait_cyc(r + 5);
        set_req(1, 32'h8100, 16'd6);
        set_req(3, 32'h8300, 16'd7);
        #1 rst_n = 1'b0;
        #1 chk_reset("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc + 1;
        push(K_RDY, 1, 32'h8100, 16'd6, r);
        push(K_GO,  1, 32'h8100, 16'd6, r);
        wait_cyc(r);
        bus.req_valid = '0;
        wait_cyc(r + 3);
        bus.Rd_done = 1'b1;
        push(K_DONE, 1, 32'h8100, 16'd6, r + 4);
        wait_cyc(r + 4);
        bus.Rd_done = 1'b0;
        wait_cyc(r + 10);

        while (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: got nothing, expected %h", e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmac_rd_arbiter.md
# dmac_rd_arbiter

Round-robin scheduler that shares the single read-command channel of the DMAC (Rd_go / Rd_size / Rd_addr / Rd_done) among NUM_REQ host-side requesters. It accepts one request at a time, launches it on the DMAC and waits for completion. It returns a done or timeout pulse to the owning requester before granting the next one. It sits between the AFU's functional units and the DMAC read port; the read-data FIFO path (Rd_data / Empty / Rd_en) bypasses this block.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_WIDTH, 32, DMA byte-address width
- SIZE_WIDTH, 16, transfer-size width (cache lines)
- TIMEOUT, 65535, maximum WAIT cycles before abort; 0 disables the watchdog

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request; held until req_ready
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; slice i belongs to requester i
- req_size  in  NUM_REQ*SIZE_WIDTH  packed sizes
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse: transfer complete
- req_err  out  NUM_REQ  one-hot, 1-cycle pulse: transfer aborted by timeout
- grant_id  out  $clog2(NUM_REQ)  owner of the current or last transfer
- busy  out  1  high in ISSUE or WAIT
- Rd_go  out  1  1-cycle start strobe to the DMAC
- Rd_addr  out  ADDR_WIDTH  start address, stable from ISSUE until return to IDLE
- Rd_size  out  SIZE_WIDTH  size, stable like Rd_addr
- Rd_done  in  1  DMAC completion pulse

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- **IDLE.** If any req_valid bit is set, select the winner g by round-robin, searching from rr_ptr upward with wrap-around.
  - Register grant_id=g and latch Rd_addr/Rd_size from slice g.
  - Pulse req_ready[g] in the cycle the FSM enters the next state.
  - If size ≠ 0, go to ISSUE. If size == 0, go to RESP and set done_kind=ok; no Rd_go is issued.
- **ISSUE.** Rd_go=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT.** Increment the watchdog each cycle.
  - If Rd_done arrives, set done_kind=ok and go to RESP.
  - If the watchdog reaches TIMEOUT (and TIMEOUT≠0), set done_kind=err and go to RESP.
  - If Rd_done and timeout occur in the same cycle, Rd_done wins.
- **RESP.** Pulse req_done[g] or req_err[g] for one cycle. Set rr_ptr=(g+1) mod NUM_REQ. Go to IDLE.
- Rd_done is ignored in IDLE, ISSUE and RESP.
- Requester inputs are sampled only in IDLE. A valid that drops before ready is simply not granted.
- A single requester with req_valid held high is re-granted after each RESP. Other active requesters are not starved: maximum wait is NUM_REQ-1 transfers.
- Out-of-range pointer values never occur. rr_ptr wraps with modulo NUM_REQ, including non-power-of-2 NUM_REQ.

## Timing
- **Reset values:** state=IDLE, rr_ptr=0, grant_id=0, Rd_addr=0, Rd_size=0, Rd_go=0, busy=0, all req_ready/req_done/req_err=0, watchdog=0.
- **Reset mid-transfer:** the FSM returns to IDLE immediately. No done or err pulse is emitted. Any DMAC-side cleanup is the DMAC's own reset.
- **Latency with req_valid seen in IDLE at edge t:**
  - req_ready and state=ISSUE at t+1.
  - Rd_go at t+1 (Moore output of ISSUE).
  - WAIT from t+2.
  - Rd_done sampled at edge u gives RESP at u+1, with req_done high for that cycle.
  - IDLE at u+2, and a new grant is possible at u+2 (ready at u+3).
- **Zero-size latency:** req_ready at t+1, req_done at t+2.
- **Timeout:** req_err is asserted TIMEOUT+2 cycles after Rd_go.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Single request:** req_valid[2]=1, addr=0x1000, size=8. Expect req_ready[2] at t+1; Rd_go once with Rd_addr=0x1000, Rd_size=8; Rd_done after 20 cycles; then req_done[2] one cycle later and grant_id=2.
- **Round-robin fairness:** all four valid permanently, each Rd_done returned 5 cycles after Rd_go. Expect grant order 0,1,2,3,0,1 and exactly one Rd_go per grant.
- **Zero size:** req_valid[1], size=0. Expect req_ready[1] then req_done[1] on the next cycle, with Rd_go never asserted.
- **Timeout:** TIMEOUT=10, no Rd_done returned. Expect req_err[g] 12 cycles after Rd_go and no req_done. A later spurious Rd_done in IDLE is ignored.
- **Simultaneous events and stray done:**
  - Rd_done on the same cycle the watchdog hits TIMEOUT gives req_done, not req_err.
  - Rd_done during ISSUE is ignored; completion still waits for a Rd_done in WAIT.
- **Reset mid-WAIT:** drop rst_n. Expect all outputs at their reset values asynchronously and no pulses. After release, the first grant goes to the lowest-indexed valid requester.
